// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath width, ALU opcodes, EX-stage FSM states.
package cpu_pkg;

  localparam int DW  = 16;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_ADD   = 4'd0;
  localparam logic [OPW-1:0] OP_SUB   = 4'd1;
  localparam logic [OPW-1:0] OP_AND   = 4'd2;
  localparam logic [OPW-1:0] OP_OR    = 4'd3;
  localparam logic [OPW-1:0] OP_XOR   = 4'd4;
  localparam logic [OPW-1:0] OP_SLL   = 4'd5;
  localparam logic [OPW-1:0] OP_SRL   = 4'd6;
  localparam logic [OPW-1:0] OP_PASSB = 4'd7;
  localparam logic [OPW-1:0] OP_MUL   = 4'd8;
  localparam logic [OPW-1:0] OP_DIV   = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_t;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one radix-2 step per cycle.
// hi/lo present the value after the current step, so at done they already hold the final result.
module mul_div_iter
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic          isDiv,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_b;
  logic          r_div;
  logic [3:0]    cnt;
  logic [DW:0]   mul_sum;
  logic [DW:0]   div_sh;
  logic          div_ge;

  // Operand latch on start, then advance partial product / remainder each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      r_hi  <= '0;
      r_lo  <= a;
      r_b   <= b;
      r_div <= isDiv;
      cnt   <= '0;
    end else if (step) begin
      r_hi  <= hi;
      r_lo  <= lo;
      cnt   <= cnt + 4'd1;
    end
  end

  // Single radix-2 step: multiplier adds then shifts right, divider shifts left then trial-subtracts.
  always_comb begin
    mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    div_sh  = {r_hi, r_lo[DW-1]};
    div_ge  = (div_sh >= {1'b0, r_b});
    if (r_div) begin
      hi = div_ge ? DW'(div_sh - {1'b0, r_b}) : div_sh[DW-1:0];
      lo = {r_lo[DW-2:0], div_ge};
    end else begin
      hi = mul_sum[DW:1];
      lo = {mul_sum[0], r_lo[DW-1:1]};
    end
  end

  assign done = (cnt == 4'd15);

endmodule

// File: rtl/ex_stage_buffer3.sv
// Execute stage: single-cycle ALU, multi-cycle MUL/DIV with upstream stall, EX/MEM register.
//   state | meaning
//   IDLE  | accepting; single-cycle ops complete here, MUL/DIV issue from here
//   BUSY  | iterative unit stepping; final result written at step 15
module ex_stage_buffer3
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  aluIn1,
  input  logic [DW-1:0]  aluIn2,
  input  logic [DW-1:0]  op1Datas3,
  input  logic [15:0]    instructions3,
  input  logic [OPW-1:0] aluOp,
  input  logic           mux3sels3,
  input  logic           r0Writes3,
  input  logic           regWrites3,
  input  logic           wEnables3,
  input  logic           valid3,
  input  logic           flush,
  output logic           stallOut,
  output logic [DW-1:0]  aluResult4,
  output logic [DW-1:0]  r0Data4,
  output logic [DW-1:0]  op1Datas4,
  output logic [15:0]    instructions4,
  output logic           mux3sels4,
  output logic           r0Writes4,
  output logic           regWrites4,
  output logic           wEnables4,
  output logic           valid4,
  output logic           ovf4,
  output logic           divZero4
);

  ex_state_t     state, state_nxt;
  logic          stall_c, start, step, load_single, load_multi;
  logic          is_sub, b_zero, div_zero, multi;
  logic [DW-1:0] alu_res, r0_res;
  logic          alu_ovf;
  logic          md_done;
  logic [DW-1:0] md_hi, md_lo;
  logic [DW-1:0] h_op1;
  logic [15:0]   h_instr;
  logic          h_m3, h_r0w, h_rw, h_we;

  assign b_zero   = (aluIn2 == '0);
  assign div_zero = (aluOp == OP_DIV) && b_zero;
  assign multi    = valid3 && ((aluOp == OP_MUL) || ((aluOp == OP_DIV) && !b_zero));
  assign is_sub   = (aluOp == OP_SUB);

  // Single-cycle ALU result, overflow and divide-by-zero remainder.
  always_comb begin
    alu_res = '0;
    case (aluOp)
      OP_ADD:   alu_res = aluIn1 + aluIn2;
      OP_SUB:   alu_res = aluIn1 - aluIn2;
      OP_AND:   alu_res = aluIn1 & aluIn2;
      OP_OR:    alu_res = aluIn1 | aluIn2;
      OP_XOR:   alu_res = aluIn1 ^ aluIn2;
      OP_SLL:   alu_res = aluIn1 << aluIn2[3:0];
      OP_SRL:   alu_res = aluIn1 >> aluIn2[3:0];
      OP_PASSB: alu_res = aluIn2;
      OP_DIV:   alu_res = b_zero ? '1 : '0;
      default:  alu_res = '0;
    endcase
    alu_ovf = ((aluOp == OP_ADD) || is_sub) &&
              (aluIn1[DW-1] == (aluIn2[DW-1] ^ is_sub)) &&
              (alu_res[DW-1] != aluIn1[DW-1]);
    r0_res  = div_zero ? aluIn1 : '0;
  end

  mul_div_iter u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .step  (step),
    .isDiv (aluOp == OP_DIV),
    .a     (aluIn1),
    .b     (aluIn2),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, stall and EX/MEM load selects; flush overrides everything.
  always_comb begin
    state_nxt   = state;
    stall_c     = 1'b0;
    start       = 1'b0;
    step        = 1'b0;
    load_single = 1'b0;
    load_multi  = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (multi) begin
            stall_c   = 1'b1;
            start     = 1'b1;
            state_nxt = BUSY;
          end else begin
            load_single = 1'b1;
          end
        end
        BUSY: begin
          step = 1'b1;
          if (md_done) begin
            load_multi = 1'b1;
            state_nxt  = IDLE;
          end else begin
            stall_c = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign stallOut = stall_c && rst_n;

  // Capture forwarded fields at issue so the result pairs with its own instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_op1   <= '0;
      h_instr <= '0;
      {h_m3, h_r0w, h_rw, h_we} <= '0;
    end else if (start) begin
      h_op1   <= op1Datas3;
      h_instr <= instructions3;
      {h_m3, h_r0w, h_rw, h_we} <= {mux3sels3, r0Writes3, regWrites3, wEnables3};
    end
  end

  // EX/MEM register; anything other than a completed op loads a bubble (flags cleared, data held).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluResult4    <= '0;
      r0Data4       <= '0;
      op1Datas4     <= '0;
      instructions4 <= '0;
      {mux3sels4, r0Writes4, regWrites4, wEnables4, valid4, ovf4, divZero4} <= '0;
    end else if (load_multi) begin
      aluResult4    <= md_lo;
      r0Data4       <= md_hi;
      op1Datas4     <= h_op1;
      instructions4 <= h_instr;
      {mux3sels4, r0Writes4, regWrites4, wEnables4} <= {h_m3, h_r0w, h_rw, h_we};
      {valid4, ovf4, divZero4} <= 3'b100;
    end else if (load_single && valid3) begin
      aluResult4    <= alu_res;
      r0Data4       <= r0_res;
      op1Datas4     <= op1Datas3;
      instructions4 <= instructions3;
      {mux3sels4, r0Writes4, regWrites4, wEnables4} <= {mux3sels3, r0Writes3, regWrites3, wEnables3};
      {valid4, ovf4, divZero4} <= {1'b1, alu_ovf, div_zero};
    end else begin
      {mux3sels4, r0Writes4, regWrites4, wEnables4, valid4, ovf4, divZero4} <= '0;
    end
  end

endmodule

// File: tb/tb_ex_stage_buffer3.sv
// Scoreboard bench for the execute stage: expectations queued at issue, compared when valid4 appears.
module tb_ex_stage_buffer3;
  import cpu_pkg::*;

  logic           clk, rst_n;
  logic [DW-1:0]  aluIn1, aluIn2, op1Datas3;
  logic [15:0]    instructions3;
  logic [OPW-1:0] aluOp;
  logic           mux3sels3, r0Writes3, regWrites3, wEnables3, valid3, flush;
  logic           stallOut;
  logic [DW-1:0]  aluResult4, r0Data4, op1Datas4;
  logic [15:0]    instructions4;
  logic           mux3sels4, r0Writes4, regWrites4, wEnables4, valid4, ovf4, divZero4;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] r0;
    logic [15:0] op1;
    logic [15:0] instr;
    logic [3:0]  ctl;
    logic        ovf;
    logic        dz;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  ex_stage_buffer3 dut (
    .clk(clk), .rst_n(rst_n), .aluIn1(aluIn1), .aluIn2(aluIn2), .op1Datas3(op1Datas3),
    .instructions3(instructions3), .aluOp(aluOp), .mux3sels3(mux3sels3), .r0Writes3(r0Writes3),
    .regWrites3(regWrites3), .wEnables3(wEnables3), .valid3(valid3), .flush(flush),
    .stallOut(stallOut), .aluResult4(aluResult4), .r0Data4(r0Data4), .op1Datas4(op1Datas4),
    .instructions4(instructions4), .mux3sels4(mux3sels4), .r0Writes4(r0Writes4),
    .regWrites4(regWrites4), .wEnables4(wEnables4), .valid4(valid4), .ovf4(ovf4), .divZero4(divZero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int s;
    logic [31:0] p;
    e = '0;
    case (op)
      4'd0: begin s = int'($signed(a)) + int'($signed(b)); e.res = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
      4'd1: begin s = int'($signed(a)) - int'($signed(b)); e.res = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: begin p = {16'd0, a} << b[3:0]; e.res = p[15:0]; end
      4'd6: e.res = a >> b[3:0];
      4'd7: e.res = b;
      4'd8: begin p = {16'd0, a} * {16'd0, b}; e.res = p[15:0]; e.r0 = p[31:16]; end
      4'd9: begin
        if (b == 16'd0) begin e.res = 16'hFFFF; e.r0 = a; e.dz = 1'b1; end
        else begin e.res = a / b; e.r0 = a % b; end
      end
      default: e.res = 16'd0;
    endcase
    return e;
  endfunction

  // Compare each produced result with the oldest expectation; bubbles must have all flags low.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid4) begin
        if (sb.size() == 0) check("unexpected_valid4", {31'd0, valid4}, 32'd0);
        else begin
          e = sb.pop_front();
          check("latency_cycle", cyc, e.cyc);
          check("aluResult4", {16'd0, aluResult4}, {16'd0, e.res});
          check("r0Data4", {16'd0, r0Data4}, {16'd0, e.r0});
          check("op1Datas4", {16'd0, op1Datas4}, {16'd0, e.op1});
          check("instructions4", {16'd0, instructions4}, {16'd0, e.instr});
          check("ctl4", {28'd0, mux3sels4, r0Writes4, regWrites4, wEnables4}, {28'd0, e.ctl});
          check("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
          check("divZero4", {31'd0, divZero4}, {31'd0, e.dz});
        end
      end else begin
        check("bubble_flags", {25'd0, mux3sels4, r0Writes4, regWrites4, wEnables4, ovf4, divZero4, 1'b0}, 32'd0);
      end
    end
  end

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    bit   mc, fin, s;
    int   st;
    e = model(op, a, b);
    op1Datas3     = 16'($urandom);
    instructions3 = 16'($urandom);
    {mux3sels3, r0Writes3, regWrites3, wEnables3} = 4'($urandom_range(0, 15));
    e.op1   = op1Datas3;
    e.instr = instructions3;
    e.ctl   = {mux3sels3, r0Writes3, regWrites3, wEnables3};
    mc      = (op == 4'd8) || (op == 4'd9 && b != 16'd0);
    e.cyc   = 32'(cyc + (mc ? 17 : 1));
    aluOp = op; aluIn1 = a; aluIn2 = b; valid3 = 1'b1;
    sb.push_back(e);
    st = 0; fin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s = stallOut;
      if (s) st++;
      @(posedge clk); #1;
      if (!s) begin fin = 1'b1; break; end
    end
    check({tag, "_accepted"}, {31'd0, fin}, 32'd1);
    check({tag, "_stall_cycles"}, st, mc ? 32'd16 : 32'd0);
    valid3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid3 = 1'b0; aluOp = '0; aluIn1 = '0; aluIn2 = '0;
    op1Datas3 = '0; instructions3 = '0;
    {mux3sels3, r0Writes3, regWrites3, wEnables3} = '0;
    #1;
    aluOp = OP_MUL; valid3 = 1'b1;
    #1;
    check("reset_stallOut", {31'd0, stallOut}, 32'd0);
    check("reset_outputs", {aluResult4, r0Data4}, 32'd0);
    check("reset_flags", {25'd0, mux3sels4, r0Writes4, regWrites4, wEnables4, valid4, ovf4, divZero4}, 32'd0);
    valid3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001);
    run_op("mul", OP_MUL, 16'h1234, 16'h0010);
    run_op("div", OP_DIV, 16'd100, 16'd7);
    run_op("div0", OP_DIV, 16'h0055, 16'h0000);
    run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001);
    run_op("and", OP_AND, 16'hF0F0, 16'h3C3C);
    run_op("or", OP_OR, 16'hF000, 16'h000F);
    run_op("xor", OP_XOR, 16'hAAAA, 16'hFFFF);
    run_op("sll", OP_SLL, 16'h8421, 16'h0013);
    run_op("srl", OP_SRL, 16'h8421, 16'h000F);
    run_op("passb", OP_PASSB, 16'h1111, 16'hBEEF);
    run_op("op12", 4'd12, 16'h1234, 16'h5678);
    run_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF);
    run_op("div_big", OP_DIV, 16'hFFFF, 16'h0001);

    // Flush a MUL at step 5; the stage must drop it and accept the next op immediately.
    aluOp = OP_MUL; aluIn1 = 16'h0101; aluIn2 = 16'h0202; valid3 = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stallOut", {31'd0, stallOut}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid4", {31'd0, valid4}, 32'd0);
    run_op("add_after_flush", OP_ADD, 16'd2, 16'd3);

    // Async reset in the middle of a DIV.
    aluOp = OP_DIV; aluIn1 = 16'h1234; aluIn2 = 16'h0003; valid3 = 1'b1;
    @(posedge clk); #1;
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midreset_aluResult4", {16'd0, aluResult4}, 32'd0);
    check("midreset_data", {op1Datas4, instructions4}, 32'd0);
    check("midreset_r0Data4", {16'd0, r0Data4}, 32'd0);
    check("midreset_flags", {24'd0, stallOut, mux3sels4, r0Writes4, regWrites4, wEnables4, valid4, ovf4, divZero4}, 32'd0);
    valid3 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("sub_after_reset", OP_SUB, 16'd5, 16'd7);

    run_op("b2b_mul", OP_MUL, 16'h00FF, 16'h0101);
    run_op("b2b_div", OP_DIV, 16'hC350, 16'h00FB);

    for (int i = 0; i < 12; i++) begin
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = (i % 5 == 0) ? 16'd0 : 16'($urandom);
      run_op("rand", rop, ra, rb);
    end

    valid3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
